// File: rtl/apb_timer_regs.sv
// APB2 completer: eight 32-bit registers plus a compare-match timer that
// raises a level interrupt. No wait states; every transfer is one setup
// cycle followed by one access cycle.
module apb_timer_regs #(
  parameter int SEL_IDX = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  pselx,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_STATUS  = 3'd1;
  localparam logic [2:0] IDX_COUNT   = 3'd2;
  localparam logic [2:0] IDX_COMPARE = 3'd3;

  state_t      state;
  logic        sel;
  logic        setupPhase;
  logic        accessPhase;
  logic        protErr;
  logic        wrEn;
  logic        rdCapture;
  logic [2:0]  word;
  logic [1:0]  ctrl;
  logic [1:0]  status;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] scratch [4];
  logic        match;
  logic [1:0]  w1cMask;
  logic [31:0] rdWord;
  logic        unusedBits;

  assign sel         = pselx[SEL_IDX];
  assign word        = paddr[4:2];
  assign setupPhase  = sel & ~penable;
  assign accessPhase = sel & penable;
  // An access phase is only legitimate directly after a setup phase; the
  // FSM state lags the bus phase by one cycle, so that means state SETUP.
  assign protErr     = accessPhase & (state != SETUP);
  assign wrEn        = accessPhase & (state == SETUP) & pwrite;
  assign rdCapture   = setupPhase & ~pwrite;
  assign match       = ctrl[0] & (count == compare);
  assign w1cMask     = (wrEn && word == IDX_STATUS) ? pwdata[1:0] : 2'b00;
  assign irq         = ctrl[1] & status[0];
  assign unusedBits  = ^{pselx, paddr[31:5], paddr[1:0]};

  // Bus phase tracker; a protocol error always drops back to IDLE.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else if (!sel) begin
      state <= IDLE;
    end else if (setupPhase) begin
      state <= SETUP;
    end else if (state == SETUP) begin
      state <= ACCESS;
    end else begin
      state <= IDLE;
    end
  end

  // Control register: only the two enable bits are stored.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ctrl <= 2'b00;
    end else if (wrEn && word == IDX_CTRL) begin
      ctrl <= pwdata[1:0];
    end
  end

  // Status bits: write-one-to-clear, but a same-cycle hardware set wins.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      status <= 2'b00;
    end else begin
      status <= (status & ~w1cMask) | {protErr, match};
    end
  end

  // Free-running counter that wraps to zero on compare; bus writes win.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      count <= 32'd0;
    end else if (wrEn && word == IDX_COUNT) begin
      count <= pwdata;
    end else if (ctrl[0]) begin
      count <= match ? 32'd0 : count + 32'd1;
    end
  end

  // Compare value and scratch words are plain storage.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      compare <= 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) scratch[i] <= 32'd0;
    end else if (wrEn) begin
      if (word == IDX_COMPARE) compare <= pwdata;
      if (word[2]) scratch[word[1:0]] <= pwdata;
    end
  end

  // Read mux over the register map; unused bits read as zero.
  always_comb begin
    rdWord = 32'd0;
    case (word)
      IDX_CTRL:    rdWord = {30'd0, ctrl};
      IDX_STATUS:  rdWord = {30'd0, status};
      IDX_COUNT:   rdWord = count;
      IDX_COMPARE: rdWord = compare;
      default:     rdWord = scratch[word[1:0]];
    endcase
  end

  // Read data is captured at the end of the setup phase and held.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      prdata <= 32'd0;
    end else if (rdCapture) begin
      prdata <= rdWord;
    end
  end

endmodule

// File: tb/tb_apb_timer_regs.sv
// Directed bench for apb_timer_regs: register map, timer cadence, W1C
// collisions, protocol errors, select decoding and mid-transfer reset.
module tb_apb_timer_regs;

  logic        hclk;
  logic        hresetn;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        irq;

  int total;
  int bad;
  logic [31:0] rd;
  logic [31:0] resetVals [8];

  apb_timer_regs #(.SEL_IDX(1)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .irq     (irq)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete APB transfer; rdata is prdata sampled in the access phase.
  task automatic applyStimulus(input logic wr, input logic [2:0] selVec,
                               input logic [31:0] addr, input logic [31:0] data,
                               output logic [31:0] rdata);
    @(posedge hclk); #1;
    pselx = selVec; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge hclk); #1;
    penable = 1'b1;
    rdata = prdata;
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetVals = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    hresetn = 1'b1; pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    #2 hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    checkOutput("rstPrdata", prdata, 32'd0);
    checkOutput("rstIrq", {31'd0, irq}, 32'd0);
    hresetn = 1'b1;

    // Reset values of every word
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'b010, 32'(i * 4), 32'd0, rd);
      checkOutput($sformatf("rstWord%0d", i), rd, resetVals[i]);
    end

    // Scratch writes then back-to-back reads
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 3'b010, 32'h10 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), rd);
    for (int i = 0; i < 4; i++) begin
      @(posedge hclk); #1;
      pselx = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10 + 32'(i * 4);
      @(posedge hclk); #1;
      penable = 1'b1;
      checkOutput($sformatf("b2bScratch%0d", i), prdata, 32'hA5A5_0000 + 32'(i));
    end
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0;

    applyStimulus(1'b1, 3'b010, 32'h0, 32'hFFFF_FFFF, rd);
    applyStimulus(1'b0, 3'b010, 32'h0, 32'd0, rd);
    checkOutput("ctrlMask", rd, 32'h3);

    // Timer cadence with COMPARE = 4
    applyStimulus(1'b1, 3'b010, 32'h0, 32'd0, rd);
    applyStimulus(1'b1, 3'b010, 32'h8, 32'd0, rd);
    applyStimulus(1'b1, 3'b010, 32'hC, 32'd4, rd);
    applyStimulus(1'b0, 3'b010, 32'hC, 32'd0, rd);
    checkOutput("compareRd", rd, 32'd4);
    applyStimulus(1'b1, 3'b010, 32'h0, 32'h3, rd);
    checkOutput("count0", dut.count, 32'd0);
    checkOutput("irqPre", {31'd0, irq}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge hclk); #1;
      checkOutput($sformatf("count%0d", k), dut.count, (k == 5) ? 32'd0 : 32'(k));
      checkOutput($sformatf("irqCyc%0d", k), {31'd0, irq}, (k == 5) ? 32'd1 : 32'd0);
    end

    // W1C commit lands on the next match edge: set must win
    repeat (2) @(posedge hclk);
    applyStimulus(1'b1, 3'b010, 32'h4, 32'd1, rd);
    checkOutput("w1cSetWins", {31'd0, irq}, 32'd1);
    applyStimulus(1'b1, 3'b010, 32'h0, 32'h2, rd);
    checkOutput("irqHeld", {31'd0, irq}, 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'd0, rd);
    checkOutput("countFrozen", rd, 32'd3);
    applyStimulus(1'b0, 3'b010, 32'h4, 32'd0, rd);
    checkOutput("statusSet", rd, 32'd1);
    applyStimulus(1'b1, 3'b010, 32'h4, 32'd1, rd);
    applyStimulus(1'b0, 3'b010, 32'h4, 32'd0, rd);
    checkOutput("statusClr", rd, 32'd0);
    checkOutput("irqClr", {31'd0, irq}, 32'd0);

    // Access phase with no setup: no write, error flagged
    @(posedge hclk); #1;
    pselx = 3'b010; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hDEAD_BEEF;
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, rd);
    checkOutput("protNoWrite", rd, 32'hA5A5_0000);
    applyStimulus(1'b0, 3'b010, 32'h4, 32'd0, rd);
    checkOutput("protStatus", rd, 32'h2);

    // Transfer on the wrong select bit is ignored
    applyStimulus(1'b1, 3'b001, 32'h14, 32'h1234_5678, rd);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'd0, rd);
    checkOutput("wrongSel", rd, 32'hA5A5_0001);

    // Reset between setup and access of a write
    @(posedge hclk); #1;
    pselx = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h0000_CAFE;
    #4 hresetn = 1'b0;
    #1;
    checkOutput("midRstPrdata", prdata, 32'd0);
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
    hresetn = 1'b1;
    checkOutput("midRstIrq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'b010, 32'(i * 4), 32'd0, rd);
      checkOutput($sformatf("postRstWord%0d", i), rd, resetVals[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
